// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer.
//   - Opcode constants understood by the 4-bit ALU.
//   - Opcode/operand/result widths and the packed command layout.
//   - Issuer FSM state encoding.
// Optional build macro ALU_ERRCHK_EN (used by the issuer) rejects opcode 0xF
// and divide-by-zero before they reach the ALU.
package alu_pkg;

  localparam int unsigned OPW = 4;
  localparam int unsigned DW  = 4;
  localparam int unsigned RW  = 8;
  // Packed command width: {opt, a, b}
  localparam int unsigned CW  = OPW + 2 * DW;

  localparam logic [OPW-1:0] OP_ADD  = 4'h0;
  localparam logic [OPW-1:0] OP_SUB  = 4'h1;
  localparam logic [OPW-1:0] OP_MUL  = 4'h2;
  localparam logic [OPW-1:0] OP_DIV  = 4'h3;
  localparam logic [OPW-1:0] OP_SHL  = 4'h4;
  localparam logic [OPW-1:0] OP_SHR  = 4'h5;
  localparam logic [OPW-1:0] OP_ROL  = 4'h6;
  localparam logic [OPW-1:0] OP_ROR  = 4'h7;
  localparam logic [OPW-1:0] OP_AND  = 4'h8;
  localparam logic [OPW-1:0] OP_OR   = 4'h9;
  localparam logic [OPW-1:0] OP_XOR  = 4'hA;
  localparam logic [OPW-1:0] OP_NOR  = 4'hB;
  localparam logic [OPW-1:0] OP_NAND = 4'hC;
  localparam logic [OPW-1:0] OP_XNOR = 4'hD;
  localparam logic [OPW-1:0] OP_NOT  = 4'hE;
  // Unassigned opcode; treated as illegal when error checking is built in.
  localparam logic [OPW-1:0] OP_RSVD = 4'hF;

  typedef struct packed {
    logic [OPW-1:0] opt;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
  } cmd_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } issuer_state_e;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Handshake bundle for the ALU command issuer.
//   Upstream command channel : in_valid/in_ready, in_opt, in_a, in_b
//   ALU side                 : alu_opt, alu_a, alu_b (to ALU), alu_res (from ALU)
//   Downstream result channel: out_valid/out_ready, out_data, out_opt
//   Status                   : busy, plus err when built with ALU_ERRCHK_EN
// Modport master is the issuer's view; slave is the surrounding system's view.
interface alu_cmd_issuer_if;
  import alu_pkg::*;

  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_opt;
  logic [DW-1:0]  in_a;
  logic [DW-1:0]  in_b;
  logic [OPW-1:0] alu_opt;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [RW-1:0]  alu_res;
  logic           out_valid;
  logic           out_ready;
  logic [RW-1:0]  out_data;
  logic [OPW-1:0] out_opt;
  logic           busy;
`ifdef ALU_ERRCHK_EN
  logic           err;

  modport master (
    input  in_valid, in_opt, in_a, in_b, alu_res, out_ready,
    output in_ready, alu_opt, alu_a, alu_b, out_valid, out_data, out_opt, busy, err
  );

  modport slave (
    output in_valid, in_opt, in_a, in_b, alu_res, out_ready,
    input  in_ready, alu_opt, alu_a, alu_b, out_valid, out_data, out_opt, busy, err
  );
`else
  modport master (
    input  in_valid, in_opt, in_a, in_b, alu_res, out_ready,
    output in_ready, alu_opt, alu_a, alu_b, out_valid, out_data, out_opt, busy
  );

  modport slave (
    output in_valid, in_opt, in_a, in_b, alu_res, out_ready,
    input  in_ready, alu_opt, alu_a, alu_b, out_valid, out_data, out_opt, busy
  );
`endif

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the ALU command issuer.
//   clk, reset    : rising-edge clock, asynchronous active-low reset
//   push, wdata   : write request and data (ignored while full)
//   pop, rdata    : read request (ignored while empty); rdata shows the head
//   count         : number of stored entries, log2(Depth)+1 bits
//   full, empty   : derived from the registered count
// Depth must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  // A full FIFO refuses a push even if the same cycle pops.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: buffers (opcode, A, B) commands, issues them one at a
// time to the ALU, waits the ALU latency, captures the result and offers it
// downstream with a valid/ready handshake.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   bus        : alu_cmd_issuer_if.master (command in, ALU drive, result out, busy)
// Parameters : FIFO_DEPTH (power of two, >= 2), ALU_LAT (>= 1)
// Build macro: ALU_ERRCHK_EN adds bus.err and completes opcode 0xF and
//              divide-by-zero locally with a zero result instead of issuing them.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ALU_LAT    = 1
) (
  input  logic             clk,
  input  logic             reset,
  alu_cmd_issuer_if.master bus
);

  localparam int unsigned CntW     = $clog2(ALU_LAT + 1);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;

  issuer_state_e         state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  cmd_t                  alu_cmd_q, alu_cmd_d;
  logic                  out_valid_q, out_valid_d;
  logic [RW-1:0]         out_data_q, out_data_d;
  logic [OPW-1:0]        out_opt_q, out_opt_d;
  logic                  rdy_q;

  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [FifoCntW-1:0]   fifo_count;
  logic [CW-1:0]         head_raw;
  cmd_t                  head;
  logic                  reject;

`ifdef ALU_ERRCHK_EN
  logic                  err_q, err_d;
  assign reject = (head.opt == OP_RSVD) || ((head.opt == OP_DIV) && (head.b == '0));
`else
  assign reject = 1'b0;
`endif

  // in_ready stays low while in reset and goes high on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
    end
  end

  assign bus.in_ready = rdy_q & ~fifo_full;
  assign push         = bus.in_valid & bus.in_ready;

  alu_cmd_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.in_opt, bus.in_a, bus.in_b}),
    .rdata (head_raw),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = cmd_t'(head_raw);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_cmd_d   = alu_cmd_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_opt_d   = out_opt_q;
    pop         = 1'b0;
`ifdef ALU_ERRCHK_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (reject) begin
            // Illegal commands never reach the ALU; ALU inputs keep their old value.
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_opt_d   = head.opt;
`ifdef ALU_ERRCHK_EN
            err_d       = 1'b1;
`endif
            state_d     = StHold;
          end else begin
            alu_cmd_d = head;
            cnt_d     = CntW'(ALU_LAT);
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        // The edge that takes the counter to zero is the one that sees a valid result.
        if (cnt_d == '0) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.alu_res;
          out_opt_d   = alu_cmd_q.opt;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
`ifdef ALU_ERRCHK_EN
          err_d       = 1'b0;
`endif
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      alu_cmd_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_opt_q   <= '0;
`ifdef ALU_ERRCHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_cmd_q   <= alu_cmd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_opt_q   <= out_opt_d;
`ifdef ALU_ERRCHK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.alu_opt   = alu_cmd_q.opt;
  assign bus.alu_a     = alu_cmd_q.a;
  assign bus.alu_b     = alu_cmd_q.b;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_opt   = out_opt_q;
  assign bus.busy      = (state_q != StIdle) || (fifo_count != '0);
`ifdef ALU_ERRCHK_EN
  assign bus.err       = err_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios followed by a
// randomized phase. Expected results come from an in-order queue of accepted
// commands evaluated with a behavioural ALU function.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ALU_LAT    = 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  cmd_t exp_q[$];

  alu_cmd_issuer_if bus ();

  alu_cmd_issuer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ALU_LAT    (ALU_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [RW-1:0] alu_f(input logic [OPW-1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [7:0] a8, b8, aa;
    a8 = {4'h0, a};
    b8 = {4'h0, b};
    aa = {a, a};
    case (op)
      OP_ADD:  return a8 + b8;
      OP_SUB:  return a8 - b8;
      OP_MUL:  return a8 * b8;
      OP_DIV:  return (b == 4'h0) ? 8'hFF : a8 / b8;
      OP_SHL:  return a8 << b;
      OP_SHR:  return a8 >> b;
      OP_ROL:  begin aa = aa << b[1:0]; return {4'h0, aa[7:4]}; end
      OP_ROR:  begin aa = aa >> b[1:0]; return {4'h0, aa[3:0]}; end
      OP_AND:  return {4'h0, a & b};
      OP_OR:   return {4'h0, a | b};
      OP_XOR:  return {4'h0, a ^ b};
      OP_NOR:  return {4'h0, ~(a | b)};
      OP_NAND: return {4'h0, ~(a & b)};
      OP_XNOR: return {4'h0, ~(a ^ b)};
      OP_NOT:  return {4'h0, ~a};
      OP_RSVD: return 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // ALU stand-in: inputs are held stable by the issuer from issue to capture.
  assign bus.alu_res = alu_f(bus.alu_opt, bus.alu_a, bus.alu_b);

  function automatic logic exp_err(input cmd_t c);
`ifdef ALU_ERRCHK_EN
    return (c.opt == OP_RSVD) || (c.opt == OP_DIV && c.b == 4'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [RW-1:0] exp_res(input cmd_t c);
    return exp_err(c) ? 8'h00 : alu_f(c.opt, c.a, c.b);
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.opt = 4'($urandom_range(0, 14));
    c.a   = 4'($urandom_range(0, 15));
    c.b   = 4'($urandom_range(1, 15));
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input cmd_t c, output int waits);
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_opt   = c.opt;
    bus.in_a     = c.a;
    bus.in_b     = c.b;
    while (bus.in_ready !== 1'b1 && waits < 50) begin
      tick();
      waits++;
    end
    check("push_accept", bus.in_ready, 1);
    if (bus.in_ready === 1'b1) begin
      exp_q.push_back(c);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic compare_front(input string tag);
    cmd_t c;
    check({tag, "_queue_nonempty"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      check({tag, "_data"}, bus.out_data, exp_res(c));
      check({tag, "_opt"}, bus.out_opt, c.opt);
`ifdef ALU_ERRCHK_EN
      check({tag, "_err"}, bus.err, exp_err(c));
`endif
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("out_valid_timeout", bus.out_valid, 1);
  endtask

  task automatic take_one(input string tag);
    wait_valid();
    compare_front(tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Collect n results with out_ready high; optionally check back-to-back spacing.
  task automatic drain(input int n, input bit gap_chk);
    int got, cyc, last;
    got = 0;
    cyc = 0;
    last = 0;
    bus.out_ready = 1'b1;
    while (got < n && cyc < 50 * n + 50) begin
      if (bus.out_valid === 1'b1) begin
        compare_front("drain");
        if (gap_chk && got > 0) check("throughput_gap", cyc - last, ALU_LAT + 2);
        last = cyc;
        got++;
      end
      tick();
      cyc++;
    end
    bus.out_ready = 1'b0;
    check("drain_count", got, n);
  endtask

  initial begin
    cmd_t           c;
    cmd_t           c2;
    int             w;
    int             saw;
    logic           held;
    logic [RW-1:0]  held_data;
    logic [OPW-1:0] held_opt;
`ifdef ALU_ERRCHK_EN
    logic [OPW-1:0] prev_opt;
`endif

    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opt    = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_alu_opt", bus.alu_opt, 0);
    check("rst_out_data", bus.out_data, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("ready_after_release", bus.in_ready, 1);

    // Single command: add 2+3
    bus.out_ready = 1'b1;
    c = '{opt: OP_ADD, a: 4'd2, b: 4'd3};
    push_cmd(c, w);
    for (int i = 0; i < int'(ALU_LAT); i++) begin
      tick();
      check("single_early_valid", bus.out_valid, 0);
    end
    check("single_alu_a", bus.alu_a, 2);
    check("single_alu_b", bus.alu_b, 3);
    tick();
    check("single_valid", bus.out_valid, 1);
    check("single_data", bus.out_data, 8'h05);
    check("single_opt", bus.out_opt, OP_ADD);
    compare_front("single");
    tick();
    check("single_valid_clear", bus.out_valid, 0);
    check("single_idle", bus.busy, 0);
    bus.out_ready = 1'b0;

    // FIFO fill: one in flight plus FIFO_DEPTH queued, then back-pressure
    for (int i = 0; i < int'(FIFO_DEPTH) + 1; i++) begin
      push_cmd(rand_cmd(), w);
      check("fill_accept_wait", w, 0);
    end
    check("fill_full_ready", bus.in_ready, 0);
    repeat (3) tick();
    check("fill_stall_ready", bus.in_ready, 0);
    check("fill_busy", bus.busy, 1);
    take_one("fill_first");
    push_cmd(rand_cmd(), w);
    check("fill_refill_wait", w, 1);
    drain(int'(FIFO_DEPTH) + 1, 1'b1);

    // Ordering and back-pressure: mul 3*3, sub 6-2, and 0xA&0x6
    push_cmd('{opt: OP_MUL, a: 4'd3, b: 4'd3}, w);
    push_cmd('{opt: OP_SUB, a: 4'd6, b: 4'd2}, w);
    push_cmd('{opt: OP_AND, a: 4'hA, b: 4'h6}, w);
    wait_valid();
    check("stall_first", bus.out_data, 8'h09);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_valid", bus.out_valid, 1);
      check("stall_data", bus.out_data, 8'h09);
    end
    drain(3, 1'b1);

    // Reset mid-operation with two commands still queued
    c  = rand_cmd();
    c2 = '{opt: OP_XOR, a: 4'h5, b: 4'hC};
    push_cmd(c, w);
    push_cmd(c2, w);
    push_cmd(rand_cmd(), w);
    push_cmd(rand_cmd(), w);
    take_one("rstmid_first");
    tick();
    check("rstmid_wait_alu_a", bus.alu_a, c2.a);
    check("rstmid_wait_valid", bus.out_valid, 0);
    #2;
    reset = 1'b0;
    #1;
    check("rstmid_out_valid", bus.out_valid, 0);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_in_ready", bus.in_ready, 0);
    check("rstmid_alu_a", bus.alu_a, 0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid === 1'b1) saw++;
    end
    check("rstmid_no_result", saw, 0);
    check("rstmid_ready_back", bus.in_ready, 1);
    check("rstmid_idle", bus.busy, 0);
    bus.out_ready = 1'b0;

`ifdef ALU_ERRCHK_EN
    // Illegal commands complete locally with err set
    prev_opt = bus.alu_opt;
    push_cmd('{opt: OP_DIV, a: 4'd8, b: 4'd0}, w);
    wait_valid();
    check("err_div_flag", bus.err, 1);
    check("err_div_data", bus.out_data, 0);
    check("err_div_alu_opt", bus.alu_opt, prev_opt);
    take_one("err_div");
    check("err_div_clear", bus.err, 0);
    push_cmd('{opt: OP_RSVD, a: 4'd1, b: 4'd1}, w);
    wait_valid();
    check("err_rsvd_flag", bus.err, 1);
    check("err_rsvd_alu_opt", bus.alu_opt, prev_opt);
    take_one("err_rsvd");
    push_cmd('{opt: OP_ADD, a: 4'd2, b: 4'd3}, w);
    wait_valid();
    check("err_after_data", bus.out_data, 8'h05);
    check("err_after_flag", bus.err, 0);
    take_one("err_after");
`endif

    // Randomized traffic, all opcodes, random back-pressure
    held      = 1'b0;
    held_data = '0;
    held_opt  = '0;
    for (int i = 0; i < 400; i++) begin
      c.opt         = 4'($urandom_range(0, 15));
      c.a           = 4'($urandom_range(0, 15));
      c.b           = 4'($urandom_range(0, 15));
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_opt    = c.opt;
      bus.in_a      = c.a;
      bus.in_b      = c.b;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.in_valid && bus.in_ready === 1'b1) exp_q.push_back(c);
      if (held) begin
        check("rand_hold_valid", bus.out_valid, 1);
        check("rand_hold_data", bus.out_data, held_data);
        check("rand_hold_opt", bus.out_opt, held_opt);
      end
      held = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          compare_front("rand");
        end else begin
          held      = 1'b1;
          held_data = bus.out_data;
          held_opt  = bus.out_opt;
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    drain(exp_q.size(), 1'b0);
    check("rand_final_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
